noc_out_arbiter: RTL
====================

# noc_out_arbiter

Clocked output-port arbiter for the mesh NoC. It shares one router output link (toward a neighbour router, a PE or the memblock) among `NUM_IN` input ports. Grants are round-robin and packet-locked, and accepted flits are buffered in a small output FIFO. Flits use the NoC 33-bit format: `{last[32], dst[31:28], src[27:24], data[23:0]}`.

## Interface
Parameters:
- `NUM_IN`, 5, number of requesting input ports (N, S, E, W, local)
- `WIDTH`, 33, flit width
- `FIFO_DEPTH`, 2, output buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `in_data`  in  `NUM_IN`×`WIDTH`  flit per input port
- `in_valid`  in  `NUM_IN`  port i offers a flit
- `in_ready`  out  `NUM_IN`  port i flit accepted this cycle when valid&ready
- `out_data`  out  `WIDTH`  FIFO head flit
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  downstream consumes head when valid&ready
- `grant_id`  out  `$clog2(NUM_IN)`  currently granted/locked port
- `busy`  out  1  high while in LOCKED state

## Operation
- FSM states: IDLE, LOCKED.
- IDLE: if FIFO not full, pick the first `in_valid` port scanning from `rr_ptr` upward, with modulo wrap. Assert `in_ready` for the winner only, in the same cycle (combinational). The flit is pushed.
  - Winner flit `last`=1: stay IDLE; `rr_ptr` ← winner+1 mod `NUM_IN`.
  - Winner flit `last`=0: go LOCKED; `grant_id` ← winner.
- LOCKED: `in_ready[grant_id]` = FIFO not full; all other `in_ready` are 0.
  - Accepted flit with `last`=1: return to IDLE; `rr_ptr` ← `grant_id`+1 mod `NUM_IN`.
  - Other ports' `in_valid` are ignored until the unlock.
- `in_ready` never depends on `out_ready`. A full FIFO blocks all pushes, even if a pop occurs in the same cycle.
- FIFO push and pop in the same cycle keeps the count unchanged. Pop on empty cannot happen because `out_valid`=0.
- No valid requesters: no `in_ready`; `rr_ptr` and `grant_id` are unchanged.
- Reset mid-packet: the FIFO is flushed, the lock is dropped, and the partial packet is discarded. Upstream must resend.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `in_ready`=0, `grant_id`=0, `busy`=0; FIFO count 0, `rr_ptr`=0, state IDLE.
- Latency: a flit accepted in cycle t is on `out_data` with `out_valid`=1 in cycle t+1 if the FIFO was empty. Otherwise it waits behind earlier entries.
- Throughput: 1 flit/cycle sustained when `out_ready`=1 continuously.
- `out_data`/`out_valid` come from registers; no combinational path from `in_*` to `out_*`.
- `out_data` holds stable while `out_valid`=1 and `out_ready`=0.
- `busy` and `grant_id` update on the edge that enters or leaves LOCKED.

## Structure
- Shared package `noc_pkg`:
  - `FLIT_W`=33
  - field offsets `LAST_BIT`=32, `DST_HI`=31, `DST_LO`=28, `SRC_HI`=27, `SRC_LO`=24
  - typedef `flit_t` (packed struct `last`, `dst[3:0]`, `src[3:0]`, `data[23:0]`)
  - `enum arb_state_t {IDLE, LOCKED}`
- Sub-module `noc_flit_fifo` (parameters `WIDTH`, `DEPTH`): registered head, count-based full/empty.
- Round-robin select and FSM live in the top module.

## Test plan
- Single flit 33'h1AD000155 on port 3, `out_ready`=1 → `in_ready[3]`=1 at t; `out_data`=33'h1AD000155, `out_valid`=1 at t+1; `rr_ptr`=4.
- Ports 0, 2, 4 hold valid single-flit packets continuously, `rr_ptr`=0 → grants in order 0, 2, 4, 0; each port gets exactly 1 of every 3 accepts.
- Port 1 sends 3-flit packet (`last`=0,0,1) while port 0 is valid → `busy`=1, `grant_id`=1 for all 3 flits, port 0 served on the next cycle after the unlock.
- `out_ready`=0 with 3 requesters → exactly 2 flits accepted, then all `in_ready`=0; `out_data` stable. Raise `out_ready` → drains in acceptance order.
- Full FIFO with simultaneous pop → no push that cycle; the push occurs the following cycle.
- `reset` asserted mid-packet (after flit 2 of 4) → outputs immediately at reset values, FIFO empty, state IDLE; a new single flit afterward passes normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: 33-bit flit layout, arbiter FSM states and the
// round-robin pointer helper used by the output-port arbiter.
package noc_pkg;

    localparam int FLIT_W   = 33;
    localparam int LAST_BIT = 32;
    localparam int DST_HI   = 31;
    localparam int DST_LO   = 28;
    localparam int SRC_HI   = 27;
    localparam int SRC_LO   = 24;

    typedef struct packed {
        logic        last;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [23:0] data;
    } flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Next port after cur, wrapping at n (n need not be a power of two).
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Small flit FIFO with a register-sourced head and count-based full/empty.
// A push is refused whenever the FIFO is full, even if a pop happens too.
module noc_flit_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == CW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && out_valid;
    assign out_data  = mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Output-port arbiter: round-robin, packet-locked grant of one router output
// link among NUM_IN input ports, feeding a small registered output FIFO.
module noc_out_arbiter
    import noc_pkg::*;
#(
    parameter int NUM_IN     = 5,
    parameter int WIDTH      = 33,
    parameter int FIFO_DEPTH = 2,
    localparam int PTR_W     = $clog2(NUM_IN)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_IN-1:0][WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]              in_valid,
    output logic [NUM_IN-1:0]              in_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PTR_W-1:0]               grant_id,
    output logic                           busy
);

    arb_state_t        state_reg;
    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [PTR_W-1:0]  grant_reg;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  sel;
    logic              found;
    logic              fifo_full;
    logic              accept;
    logic              flit_last;
    logic [NUM_IN-1:0] ready;

    // First valid port at or after rr_ptr, wrapping modulo NUM_IN.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!found && in_valid[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    // While locked the owner sees ready whether or not it is currently valid.
    always_comb begin
        ready = '0;
        if (!reset && !fifo_full) begin
            if (state_reg == IDLE) begin
                if (found) begin
                    ready[winner] = 1'b1;
                end
            end else begin
                ready[grant_reg] = 1'b1;
            end
        end
    end

    assign sel       = (state_reg == IDLE) ? winner : grant_reg;
    assign accept    = |(ready & in_valid);
    assign flit_last = in_data[sel][LAST_BIT];
    assign in_ready  = ready;
    assign busy      = (state_reg == LOCKED);
    assign grant_id  = grant_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            grant_reg  <= '0;
        end else if (accept) begin
            if (state_reg == IDLE) begin
                if (flit_last) begin
                    rr_ptr_reg <= PTR_W'(rr_next(int'(winner), NUM_IN));
                end else begin
                    state_reg <= LOCKED;
                    grant_reg <= winner;
                end
            end else if (flit_last) begin
                state_reg  <= IDLE;
                rr_ptr_reg <= PTR_W'(rr_next(int'(grant_reg), NUM_IN));
            end
        end
    end

    noc_flit_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (in_data[sel]),
        .full      (fifo_full),
        .pop       (out_valid && out_ready),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

endmodule
